// File: rtl/display_7seg_mux_bcd_if.sv
// Digit-pair input and segment/anode output bundle of the two-digit
// multiplexed 7-segment display driver.
//
// Handshake: there is no ready path. The master presents dezena/unidade and
// asserts carregar for one or more rising edges; every edge with carregar=1
// latches the pair. segmentos/anodos are free-running registered outputs that
// the display side samples every cycle.
interface display_7seg_mux_bcd_if;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       carregar;
    logic [6:0] segmentos;
    logic [1:0] anodos;

    // Upstream decoder (or bench) side
    modport master (
        output dezena,
        output unidade,
        output carregar,
        input  segmentos,
        input  anodos
    );

    // Display driver side
    modport slave (
        input  dezena,
        input  unidade,
        input  carregar,
        output segmentos,
        output anodos
    );
endinterface

// File: rtl/display_7seg_mux_bcd.sv
// Two-digit time-multiplexed common-anode 7-segment driver.
// Cycles BRANCO_U -> UNID -> BRANCO_D -> DEZ, with an all-off gap between the
// lit digits to avoid ghosting. A leading zero in the tens digit can be
// blanked, and non-BCD codes are shown as a dash.
module display_7seg_mux_bcd #(
    parameter int DIVISOR        = 50000,
    parameter int BLANK          = 8,
    parameter bit ATIVO_BAIXO    = 1'b1,
    parameter bit APAGA_ZERO_ESQ = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    display_7seg_mux_bcd_if.slave        bus,
    output logic [1:0]                   debug_state
);

    // Phase counter sized for the longer of the two phase lengths
    localparam int MAX_LIM = (DIVISOR > BLANK) ? DIVISOR : BLANK;
    localparam int CW      = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

    localparam logic [CW-1:0] LAST_DIV   = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK - 1);

    // All-off pin levels depend on the polarity of the board
    localparam logic [6:0] SEG_OFF = ATIVO_BAIXO ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = ATIVO_BAIXO ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        BRANCO_U = 2'd0,
        UNID     = 2'd1,
        BRANCO_D = 2'd2,
        DEZ      = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          phase_done;

    logic [3:0]    dez_reg;
    logic [3:0]    unid_reg;

    logic [1:0]    an_log;
    logic [6:0]    seg_log;
    logic [1:0]    an_pin;
    logic [6:0]    seg_pin;

    assign debug_state = state;

    // Segment pattern {g,f,e,d,c,b,a}, active-high; codes 10..15 give a dash
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Next-state and phase counter: advance when the counter hits limit-1
    always_comb begin
        state_next = state;
        count_next = count + 1'b1;
        phase_done = 1'b0;
        case (state)
            BRANCO_U: phase_done = (count == LAST_BLANK);
            UNID:     phase_done = (count == LAST_DIV);
            BRANCO_D: phase_done = (count == LAST_BLANK);
            DEZ:      phase_done = (count == LAST_DIV);
            default:  phase_done = 1'b1;
        endcase
        if (phase_done) begin
            count_next = '0;
            case (state)
                BRANCO_U: state_next = UNID;
                UNID:     state_next = BRANCO_D;
                BRANCO_D: state_next = DEZ;
                DEZ:      state_next = BRANCO_U;
                default:  state_next = BRANCO_U;
            endcase
        end
    end

    // Logical outputs for the state being entered, from the currently held
    // digits so a load shows up one edge after it is latched
    always_comb begin
        an_log  = 2'b00;
        seg_log = 7'b0000000;
        case (state_next)
            UNID: begin
                an_log  = 2'b01;
                seg_log = enc(unid_reg);
            end
            DEZ: begin
                if (!(APAGA_ZERO_ESQ && (dez_reg == 4'd0))) begin
                    an_log  = 2'b10;
                    seg_log = enc(dez_reg);
                end
            end
            default: begin
                an_log  = 2'b00;
                seg_log = 7'b0000000;
            end
        endcase
    end

    // Pin polarity applied just ahead of the output register
    always_comb begin
        an_pin  = ATIVO_BAIXO ? ~an_log  : an_log;
        seg_pin = ATIVO_BAIXO ? ~seg_log : seg_log;
    end

    // State register and phase counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BRANCO_U;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Digit latches; reset wins over a simultaneous load
    always_ff @(posedge clock) begin
        if (reset) begin
            dez_reg  <= 4'd0;
            unid_reg <= 4'd0;
        end else if (bus.carregar) begin
            dez_reg  <= bus.dezena;
            unid_reg <= bus.unidade;
        end
    end

    // Registered pin outputs, all-off while in reset
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.segmentos <= SEG_OFF;
            bus.anodos    <= AN_OFF;
        end else begin
            bus.segmentos <= seg_pin;
            bus.anodos    <= an_pin;
        end
    end

endmodule
